// File: rtl/ebc_group_arbiter_ctrl.sv
// ebc_group_arbiter_ctrl
// ----------------------
// Round-robin grant controller for one level of the event-camera pixel
// arbitration hierarchy. It takes requests from the groups below and gives one
// held one-hot grant at a time. The grant stays until the served group pulses
// grp_done_i. Each group is served at most once per round. When no un-served
// requester is left, a one-cycle grp_release_o pulse goes to the level above
// and the round mask is cleared.
//
// Handshake: a grant is offered when gnt_valid_o rises. It is held unchanged
// (gnt_o and gnt_idx_o) until the cycle after grp_done_i is sampled high.
// grp_done_i is ignored when no grant is held. grp_release_o is a single-cycle
// pulse with no back-pressure.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_n_i      synchronous active-low reset
//   en_i           arbitration enable; low blocks new grants only
//   req_i          per-group level-sensitive requests
//   grp_done_i     served group finished (single-cycle pulse)
//   gnt_o          registered one-hot grant
//   gnt_idx_o      registered binary index of the grant (holds after release)
//   gnt_valid_o    high while a grant is held
//   grp_release_o  one-cycle pulse when the round is exhausted
//   busy_o         high while in GRANT; also serves as the FSM state probe
module ebc_group_arbiter_ctrl #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               grp_done_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o,
  output logic               grp_release_o,
  output logic               busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   rmask_q, rmask_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic                 rel_q, rel_d;

  logic [NUM_REQ-1:0]   elig;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;

  // (base + off) mod NUM_REQ. This works for non-power-of-two NUM_REQ too.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IDX_W-1:0];
  endfunction

  // Groups already served in this round are masked out until the release.
  assign elig = req_i & ~rmask_q;

  // Scan from ptr upward with wrap-around. The first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && elig[wrap_add(ptr_q, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rmask_d = rmask_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    rel_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && win_found) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          idx_d          = win_idx;
          valid_d        = 1'b1;
          rmask_d[win_idx] = 1'b1;
          state_d        = GRANT;
        end else if (!win_found && (rmask_q != '0)) begin
          // The round closes even with en_i low. Nobody eligible is left.
          rel_d   = 1'b1;
          rmask_d = '0;
        end
      end
      GRANT: begin
        // req_i and en_i are ignored here. Only grp_done_i ends the grant.
        if (grp_done_i) begin
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = wrap_add(idx_q, 1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rmask_q <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rmask_q <= rmask_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      rel_q   <= rel_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign gnt_idx_o     = idx_q;
  assign gnt_valid_o   = valid_q;
  assign grp_release_o = rel_q;
  assign busy_o        = (state_q == GRANT);

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(gnt_o));
  a_gnt_iff_valid : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ((gnt_o != '0) == gnt_valid_o));
  a_gnt_idx_match : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (gnt_valid_o |-> gnt_o[gnt_idx_o]));

endmodule

// File: tb/tb_ebc_group_arbiter_ctrl.sv
// Testbench for ebc_group_arbiter_ctrl. The stimulus pushes the expected
// grant/release events into exp_q. A negedge monitor pops one entry and
// compares it each time the DUT raises gnt_valid_o or pulses grp_release_o.
// Latency and hold behaviour are checked directly at fixed cycle offsets.
module tb_ebc_group_arbiter_ctrl;
  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;
  localparam int W       = 1 + IDX_W + NUM_REQ;

  logic               clk_i;
  logic               reset_n_i;
  logic               en_i;
  logic [NUM_REQ-1:0] req_i;
  logic               grp_done_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [IDX_W-1:0]   gnt_idx_o;
  logic               gnt_valid_o;
  logic               grp_release_o;
  logic               busy_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic         prev_valid = 1'b0;

  ebc_group_arbiter_ctrl #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i), .req_i(req_i),
    .grp_done_i(grp_done_i), .gnt_o(gnt_o), .gnt_idx_o(gnt_idx_o),
    .gnt_valid_o(gnt_valid_o), .grp_release_o(grp_release_o), .busy_o(busy_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  // checking helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_gnt(input int idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    exp_q.push_back({1'b0, idx[IDX_W-1:0], oh});
  endtask

  task automatic push_rel();
    exp_q.push_back({1'b1, {(W-1){1'b0}}});
  endtask

  // monitor
  always @(negedge clk_i) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (reset_n_i) begin
      if (gnt_valid_o && !prev_valid) begin
        got = {1'b0, gnt_idx_o, gnt_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: got %0h required none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL grant_event: got %0h required %0h", got, exp);
          end
        end
      end
      if (grp_release_o) begin
        got = {1'b1, {(W-1){1'b0}}};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_release: got %0h required none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL release_event: got %0h required %0h", got, exp);
          end
        end
      end
    end
    prev_valid = reset_n_i ? gnt_valid_o : 1'b0;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    req_i      = '0;
    grp_done_i = 1'b0;
    en_i       = 1'b1;
    reset_n_i  = 1'b0;
    tick();
    tick();
    reset_n_i  = 1'b1;
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    while (!gnt_valid_o && n < 50) begin
      tick();
      n++;
    end
    check("wait_gnt_timeout", 32'(gnt_valid_o), 32'd1);
  endtask

  // Pulse grp_done_i for one cycle. When last is set, the requests drop at the same time.
  task automatic pulse_done(input logic [NUM_REQ-1:0] req_after);
    req_i      = req_after;
    grp_done_i = 1'b1;
    tick();
    grp_done_i = 1'b0;
  endtask

  initial begin
    reset_n_i  = 1'b0;
    en_i       = 1'b1;
    req_i      = 16'hFFFF;
    grp_done_i = 1'b0;

    // Reset with all requests active, then the full round 0..15 and one release.
    tick();
    tick();
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_idx", 32'(gnt_idx_o), 32'd0);
    check("rst_valid", 32'(gnt_valid_o), 32'd0);
    check("rst_release", 32'(grp_release_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) push_gnt(i);
    push_rel();
    reset_n_i = 1'b1;
    tick();
    check("first_gnt", 32'(gnt_o), 32'h0001);
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_gnt();
      check("all_idx", 32'(gnt_idx_o), 32'(i));
      pulse_done((i == NUM_REQ - 1) ? 16'h0000 : 16'hFFFF);
    end
    repeat (3) tick();

    // grp_done_i while IDLE must do nothing.
    grp_done_i = 1'b1;
    tick();
    grp_done_i = 1'b0;
    check("idle_done_busy", 32'(busy_o), 32'd0);
    check("idle_done_release", 32'(grp_release_o), 32'd0);

    // Single request: grant at N+1, done at N+3, drop at N+4, release at N+5.
    push_gnt(5);
    push_rel();
    req_i = 16'h0020;
    tick();
    check("single_gnt", 32'(gnt_o), 32'h0020);
    check("single_idx", 32'(gnt_idx_o), 32'd5);
    check("single_valid", 32'(gnt_valid_o), 32'd1);
    tick();
    tick();
    pulse_done(16'h0000);
    check("single_drop_gnt", 32'(gnt_o), 32'd0);
    check("single_drop_valid", 32'(gnt_valid_o), 32'd0);
    check("single_idx_hold", 32'(gnt_idx_o), 32'd5);
    check("single_no_early_rel", 32'(grp_release_o), 32'd0);
    tick();
    check("single_release", 32'(grp_release_o), 32'd1);
    tick();
    check("single_release_end", 32'(grp_release_o), 32'd0);

    // Fairness: 0,1,15, release, 0,1,15, release.
    do_reset();
    push_gnt(0); push_gnt(1); push_gnt(15); push_rel();
    push_gnt(0); push_gnt(1); push_gnt(15); push_rel();
    req_i = 16'h8003;
    for (int k = 0; k < 6; k++) begin
      wait_gnt();
      tick();
      tick();
      pulse_done((k == 5) ? 16'h0000 : 16'h8003);
      if (k == 0) begin
        // Exactly one idle bubble before the next grant.
        check("bubble_valid", 32'(gnt_valid_o), 32'd0);
        tick();
        check("bubble_next_gnt", 32'(gnt_valid_o), 32'd1);
      end
    end
    repeat (4) tick();

    // Round mask: group 2 comes back at once but waits for the release.
    do_reset();
    push_gnt(2); push_gnt(9); push_rel(); push_gnt(2); push_rel();
    req_i = 16'h0204;
    wait_gnt();
    tick();
    pulse_done(16'h0200);
    req_i = 16'h0204;
    wait_gnt();
    check("mask_idx9", 32'(gnt_idx_o), 32'd9);
    tick();
    pulse_done(16'h0004);
    wait_gnt();
    tick();
    pulse_done(16'h0000);
    repeat (4) tick();

    // Enable: blocked while low, held through en_i drop, round closes with en_i low.
    do_reset();
    en_i  = 1'b0;
    req_i = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en_blocked", 32'(gnt_valid_o), 32'd0);
    end
    push_gnt(8);
    push_rel();
    en_i = 1'b1;
    tick();
    check("en_idx", 32'(gnt_idx_o), 32'd8);
    check("en_valid", 32'(gnt_valid_o), 32'd1);
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en_hold", 32'(gnt_o), 32'h0100);
    end
    pulse_done(16'h0000);
    check("en_drop", 32'(gnt_valid_o), 32'd0);
    tick();
    check("en_low_release", 32'(grp_release_o), 32'd1);
    en_i = 1'b1;
    repeat (3) tick();

    // Reset mid-grant: grant drops, no release, ptr returns to 0.
    do_reset();
    push_gnt(10);
    req_i = 16'h0400;
    wait_gnt();
    check("mid_gnt", 32'(gnt_o), 32'h0400);
    tick();
    reset_n_i = 1'b0;
    tick();
    check("mid_rst_gnt", 32'(gnt_o), 32'd0);
    check("mid_rst_valid", 32'(gnt_valid_o), 32'd0);
    check("mid_rst_release", 32'(grp_release_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    push_gnt(0); push_gnt(10); push_rel();
    req_i     = 16'h0401;
    reset_n_i = 1'b1;
    tick();
    check("post_rst_idx", 32'(gnt_idx_o), 32'd0);
    check("post_rst_release", 32'(grp_release_o), 32'd0);
    tick();
    pulse_done(16'h0401);
    wait_gnt();
    tick();
    pulse_done(16'h0000);
    repeat (4) tick();

    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
